// File: rtl/qam16_iq_mapper_if.sv
// Symbol-code input and mapped I/Q output bundle for the 16QAM mapper.
interface qam16_iq_mapper_if #(
   parameter int unsigned W = 4
);
   logic                en;
   logic [3:0]          code;
   logic signed [W-1:0] i_out;
   logic signed [W-1:0] q_out;
   logic                sym_stb;
   logic [7:0]          sym_cnt;

   // Upstream side: drives enable and code, observes mapped symbols.
   modport master (
      output en, code,
      input  i_out, q_out, sym_stb, sym_cnt
   );

   // Mapper side.
   modport slave (
      input  en, code,
      output i_out, q_out, sym_stb, sym_cnt
   );
endinterface

// File: rtl/qam16_iq_mapper.sv
// 16QAM Gray mapper: samples the 4-bit code once per symbol period and emits
// signed I/Q amplitudes with a one-clock symbol strobe.
module qam16_iq_mapper #(
   parameter int unsigned SYM_DIV    = 8,
   parameter int unsigned CAP_PHASE  = 1,
   parameter int unsigned AMP        = 1,
   parameter int unsigned W          = 4,
   parameter bit          ZERO_STUFF = 1'b1
) (
   input logic               clk,
   input logic               rst,
   qam16_iq_mapper_if.slave  bus
);

   localparam int unsigned CntW = (SYM_DIV < 2) ? 1 : $clog2(SYM_DIV);
   localparam logic [CntW-1:0] CntMax = CntW'(SYM_DIV - 1);
   localparam logic [CntW-1:0] CapCnt = CntW'(CAP_PHASE);
   localparam logic signed [W-1:0] AmpLo = W'(AMP);
   localparam logic signed [W-1:0] AmpHi = W'(3 * AMP);

   if (SYM_DIV < 2) begin : g_bad_div
      $error("qam16_iq_mapper: SYM_DIV must be >= 2");
   end
   if (CAP_PHASE >= SYM_DIV) begin : g_bad_phase
      $error("qam16_iq_mapper: CAP_PHASE must be < SYM_DIV");
   end
   if ((3 * AMP) > ((2 ** (W - 1)) - 1)) begin : g_bad_amp
      $error("qam16_iq_mapper: 3*AMP does not fit in W signed bits");
   end

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      code_q, code_d;
   logic            stb_q, stb_d;
   logic            valid_q, valid_d;   // a mapped symbol is held for display
   logic [7:0]      sym_cnt_q, sym_cnt_d;
   logic            capture;
   logic            show;

   // Gray map: 00 -> -3A, 01 -> -A, 11 -> +A, 10 -> +3A.
   function automatic logic signed [W-1:0] gray_map(input logic [1:0] b);
      logic signed [W-1:0] v;
      case (b)
         2'b00:   v = -AmpHi;
         2'b01:   v = -AmpLo;
         2'b11:   v = AmpLo;
         default: v = AmpHi;
      endcase
      return v;
   endfunction

   // en is checked first, so a falling en on the capture phase blocks the capture.
   assign capture = bus.en && (cnt_q == CapCnt);

   // Next-state: symbol counter, code capture, strobe and symbol count.
   always_comb begin
      cnt_d     = cnt_q;
      code_d    = code_q;
      stb_d     = 1'b0;
      valid_d   = valid_q;
      sym_cnt_d = sym_cnt_q;
      if (!bus.en) begin
         cnt_d   = '0;
         valid_d = 1'b0;
      end else begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
         if (capture) begin
            code_d    = bus.code;
            stb_d     = 1'b1;
            valid_d   = 1'b1;
            sym_cnt_d = sym_cnt_q + 8'd1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         code_q    <= '0;
         stb_q     <= 1'b0;
         valid_q   <= 1'b0;
         sym_cnt_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         stb_q     <= stb_d;
         valid_q   <= valid_d;
         sym_cnt_q <= sym_cnt_d;
      end
   end

   // Outputs come straight from registers; zero-stuffing shows I/Q only on the strobe.
   always_comb begin
      show        = ZERO_STUFF ? stb_q : valid_q;
      bus.i_out   = show ? gray_map(code_q[3:2]) : '0;
      bus.q_out   = show ? gray_map(code_q[1:0]) : '0;
      bus.sym_stb = stb_q;
      bus.sym_cnt = sym_cnt_q;
   end

endmodule
